dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder that serves the processor datapath's load/store requests over a valid/ready request channel and a valid/ready response channel. It sits on the far side of the datapath's data-memory port (address from the ALU result, store data from register read port 2, read/write strobes from the control unit). It replaces the zero-latency combinational data memory so the core can be exercised against configurable wait states and error responses. Word-addressed storage, byte addresses on the interface.

## Interface
- DEPTH, 256, number of 32-bit words stored (power of two, 4..4096)
- WAIT_CYCLES, 2, extra wait cycles inserted before each access (0..15)
- ADDR_BASE, 32'h0000_0000, byte address of word 0 (word-aligned)

- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  requester presents a request
- req_ready  out  1  responder can accept a request (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- resp_valid  out  1  response available
- resp_ready  in  1  requester consumes response
- resp_rdata  out  32  load data (0 for stores and errors)
- resp_err  out  1  request was misaligned or out of range

## Operation
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch req_write, req_addr, req_wdata; load wait counter with WAIT_CYCLES; go WAIT if WAIT_CYCLES>0, else ACCESS.
- WAIT: counter decrements each cycle; at 1 -> ACCESS on next edge. Request inputs ignored.
- ACCESS: single cycle. Decode latched address: offset = addr - ADDR_BASE; index = offset>>2 (unsigned 32-bit arithmetic, wrap allowed).
  - Error if addr[1:0]!=0, or addr<ADDR_BASE, or index>=DEPTH. Error: no memory write, resp_rdata=0, resp_err=1.
  - Valid store: mem[index]<=wdata at the ACCESS edge; resp_rdata=0, resp_err=0.
  - Valid load: resp_rdata<=mem[index], resp_err=0.
  - Go RESP.
- RESP: resp_valid=1; resp_rdata/resp_err held stable until resp_valid&&resp_ready, then -> IDLE, resp_valid drops, resp_rdata/resp_err cleared to 0.
- One outstanding request; no request is accepted in WAIT/ACCESS/RESP.
- Load after store to same address returns stored value (store completes in ACCESS before any later request is accepted).

## Timing
- Reset values: state IDLE, resp_valid=0, resp_rdata=0, resp_err=0, counter=0; req_ready decodes from state and reads 1 once in IDLE. Memory array is not reset.
- Latency: request accepted at edge E; resp_valid high after edge E+WAIT_CYCLES+1 (WAIT_CYCLES=0 -> one cycle).
- With resp_ready tied high: RESP lasts 1 cycle; next accept possible at edge E+WAIT_CYCLES+3; throughput one request per WAIT_CYCLES+3 cycles.
- resp_ready low: RESP held indefinitely, outputs frozen.
- req_valid asserted while req_ready=0: no effect, request must be held by requester.
- Reset asserted mid-operation (WAIT, ACCESS or RESP): immediately back to IDLE, pending response discarded; a store whose ACCESS edge coincides with or follows reset assertion is not performed.
- resp_rdata/resp_err change only on edges entering RESP or leaving it.

## Test plan
- WAIT_CYCLES=2: store 32'hDEAD_BEEF to 32'h0000_0010, then load 32'h0000_0010 -> store response rdata=0, err=0; load response rdata=32'hDEAD_BEEF, err=0; each resp_valid rises 3 edges after accept.
- Misaligned store 32'h1234_5678 to 32'h0000_0012, then load 32'h0000_0010 -> store resp_err=1; load returns prior value 32'hDEAD_BEEF.
- Out of range with DEPTH=256: load 32'h0000_0400 -> resp_err=1, rdata=0; ADDR_BASE=32'h1000_0000, load 32'h0000_0000 -> resp_err=1.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid -> resp_valid, rdata, err stable, req_ready=0 throughout; release -> IDLE next edge, req_ready=1.
- WAIT_CYCLES=0, resp_ready=1, back-to-back loads of index 0..3 -> each resp_valid one cycle after accept; accepts spaced 3 cycles.
- Store 32'hCAFE_0001 to 32'h0000_0020 with WAIT_CYCLES=4, pulse rst_n low during WAIT -> resp_valid=0, state IDLE; subsequent load of 32'h0000_0020 returns value present before the aborted store.

Source files
------------

// File: rtl/dmem_responder.sv
// Multi-cycle word-addressed data memory behind valid/ready request and response channels.
// Latency: accept edge E -> resp_valid after edge E+WAIT_CYCLES+1; one request outstanding, held in RESP until resp_ready.
module dmem_responder #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int unsigned IW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [31:0]   mem [DEPTH];

    logic [31:0]   offset;
    logic [31:0]   word_idx;
    logic [IW-1:0] mem_idx;
    logic          acc_err;
    logic          accept;

    // Addresses below the base are rejected explicitly, so the wrapped offset never aliases.
    assign offset   = addr_q - ADDR_BASE;
    assign word_idx = offset >> 2;
    assign mem_idx  = word_idx[IW-1:0];
    assign acc_err  = (addr_q[1:0] != 2'b00) || (addr_q < ADDR_BASE) || (word_idx >= DEPTH);
    assign accept   = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is not cleared, but a store still in flight is dropped while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
        end else if (state_q == S_ACCESS && wr_q && !acc_err) begin
            mem[mem_idx] <= wdata_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                rdata_d = (acc_err || wr_q) ? 32'd0 : mem[mem_idx];
                err_d   = acc_err;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == S_IDLE);
        resp_valid = (state_q == S_RESP);
        resp_rdata = rdata_q;
        resp_err   = err_q;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 wait states at base 0, zero wait at a high base)
// driven by directed and random transactions, checked against an array model of the memory.
module tb_dmem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n      [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_write  [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] mdl     [2][4096];
    bit          mdl_vld [2][4096];

    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(2), .ADDR_BASE(32'h0000_0000)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    dmem_responder #(.DEPTH(16), .WAIT_CYCLES(0), .ADDR_BASE(32'h1000_0000)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    function automatic int wc(input int u);
        return (u == 0) ? 2 : 0;
    endfunction

    function automatic int unsigned depth(input int u);
        return (u == 0) ? 256 : 16;
    endfunction

    function automatic logic [31:0] base(input int u);
        return (u == 0) ? 32'h0000_0000 : 32'h1000_0000;
    endfunction

    function automatic bit exp_err(input int u, input logic [31:0] a);
        if (a % 4 != 0) return 1'b1;
        if (a < base(u)) return 1'b1;
        return ((a - base(u)) / 4) >= depth(u);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One complete transaction; hold = cycles resp_ready stays low after resp_valid rises.
    task automatic do_req(input int u, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input int hold, output int acc);
        int          t;
        int          lat;
        int          idx;
        bit          ee;
        bit          known;
        logic [31:0] er;
        t = 0;
        while (req_ready[u] !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("idle_before_req", 32'(req_ready[u]), 32'd1);
        req_valid[u]  = 1'b1;
        req_write[u]  = wr;
        req_addr[u]   = addr;
        req_wdata[u]  = wd;
        resp_ready[u] = (hold == 0);
        @(negedge clk);
        acc = cyc;
        req_valid[u] = 1'b0;
        req_addr[u]  = $urandom;
        req_wdata[u] = $urandom;
        lat = 0;
        while (resp_valid[u] !== 1'b1 && lat < 40) begin
            chk("busy_req_ready", 32'(req_ready[u]), 32'd0);
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(wc(u) + 1));

        ee    = exp_err(u, addr);
        idx   = ee ? 0 : int'((addr - base(u)) / 4);
        known = 1'b1;
        er    = 32'd0;
        if (!ee && wr) begin
            mdl[u][idx]     = wd;
            mdl_vld[u][idx] = 1'b1;
        end else if (!ee) begin
            known = mdl_vld[u][idx];
            er    = mdl[u][idx];
        end
        chk("resp_err", 32'(resp_err[u]), 32'(ee));
        if (known) chk("resp_rdata", resp_rdata[u], er);

        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold_valid", 32'(resp_valid[u]), 32'd1);
            chk("hold_req_ready", 32'(req_ready[u]), 32'd0);
            chk("hold_err", 32'(resp_err[u]), 32'(ee));
            if (known) chk("hold_rdata", resp_rdata[u], er);
        end
        resp_ready[u] = 1'b1;
        @(negedge clk);
        chk("post_valid", 32'(resp_valid[u]), 32'd0);
        chk("post_req_ready", 32'(req_ready[u]), 32'd1);
        chk("post_rdata", resp_rdata[u], 32'd0);
        chk("post_err", 32'(resp_err[u]), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int a1;
        int prev;
        int u;
        int idx;
        logic [31:0] addr;

        for (int i = 0; i < 2; i++) begin
            rst_n[i]      = 1'b0;
            req_valid[i]  = 1'b0;
            req_write[i]  = 1'b0;
            req_addr[i]   = 32'd0;
            req_wdata[i]  = 32'd0;
            resp_ready[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_req_ready", 32'(req_ready[i]), 32'd1);
            chk("rst_resp_valid", 32'(resp_valid[i]), 32'd0);
            chk("rst_rdata", resp_rdata[i], 32'd0);
            chk("rst_err", 32'(resp_err[i]), 32'd0);
            rst_n[i] = 1'b1;
        end
        @(negedge clk);

        // Store/load, misaligned store, out of range, backpressure.
        do_req(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, a0);
        do_req(0, 1'b0, 32'h0000_0010, 32'd0, 0, a0);
        do_req(0, 1'b1, 32'h0000_0012, 32'h1234_5678, 0, a0);
        do_req(0, 1'b0, 32'h0000_0010, 32'd0, 0, a0);
        do_req(0, 1'b0, 32'h0000_0400, 32'd0, 0, a0);
        do_req(0, 1'b0, 32'h0000_0010, 32'd0, 5, a0);

        // Below-base load and back-to-back zero-wait loads of words 0..3.
        do_req(1, 1'b0, 32'h0000_0000, 32'd0, 0, a1);
        do_req(1, 1'b0, 32'h1000_0040, 32'd0, 0, a1);
        for (int i = 0; i < 4; i++)
            do_req(1, 1'b1, 32'h1000_0000 + 32'(i * 4), 32'hA5A5_0000 + 32'(i), 0, a1);
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            do_req(1, 1'b0, 32'h1000_0000 + 32'(i * 4), 32'd0, 0, a1);
            if (prev >= 0) chk("b2b_spacing", 32'(a1 - prev), 32'd3);
            prev = a1;
        end

        // Reset during WAIT discards a pending store.
        do_req(0, 1'b1, 32'h0000_0020, 32'h1111_2222, 0, a0);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h0000_0020;
        req_wdata[0] = 32'hCAFE_0001;
        resp_ready[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        chk("abort_in_wait", 32'(req_ready[0]), 32'd0);
        rst_n[0] = 1'b0;
        #1;
        chk("abort_valid", 32'(resp_valid[0]), 32'd0);
        chk("abort_req_ready", 32'(req_ready[0]), 32'd1);
        repeat (3) @(negedge clk);
        rst_n[0] = 1'b1;
        @(negedge clk);
        chk("abort_idle_valid", 32'(resp_valid[0]), 32'd0);
        do_req(0, 1'b0, 32'h0000_0020, 32'd0, 0, a0);

        // Random mix of loads/stores, errors and backpressure on both instances.
        for (int i = 0; i < 80; i++) begin
            u    = int'($urandom_range(0, 1));
            idx  = int'($urandom_range(0, depth(u) + 2));
            addr = base(u) + 32'(idx * 4);
            if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) addr = $urandom;
            if (u == 1 && $urandom_range(0, 9) == 0) addr = 32'($urandom_range(0, 1024)) * 4;
            do_req(u, 1'($urandom_range(0, 1)), addr, $urandom, int'($urandom_range(0, 3)), a0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
